// File: rtl/sfu_ctrl_if.sv
// Handshake/control bundle between sfu_ctrl and its neighbours (output FIFO,
// SFU datapath, downstream consumer). Optional perf port under SFU_CTRL_PERF_EN.
interface sfu_ctrl_if #(
    parameter int unsigned pass_bw = 4,
    parameter int unsigned out_bw  = 4
);
    logic               start;
    logic [pass_bw-1:0] num_pass;
    logic [out_bw-1:0]  num_out;
    logic               ofifo_valid;
    logic               ofifo_rd;
    logic               acc;
    logic               clr;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
`ifdef SFU_CTRL_PERF_EN
    logic [15:0]        stall_cycles;
`endif

    // Controller side
    modport master (
        input  start, num_pass, num_out, ofifo_valid, out_ready,
        output ofifo_rd, acc, clr, out_valid, busy, done
`ifdef SFU_CTRL_PERF_EN
        , output stall_cycles
`endif
    );

    // Environment side
    modport slave (
        output start, num_pass, num_out, ofifo_valid, out_ready,
        input  ofifo_rd, acc, clr, out_valid, busy, done
`ifdef SFU_CTRL_PERF_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/sfu_ctrl.sv
// SFU accumulator sequencer: per output vector, clear the accumulator, pop
// num_pass psum vectors (one acc strobe each), then offer the result downstream.
// Optional stall counter enabled by defining SFU_CTRL_PERF_EN.
module sfu_ctrl #(
    parameter int unsigned pass_bw = 4,
    parameter int unsigned out_bw  = 4
) (
    input  logic         clk,
    input  logic         reset,
    sfu_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRead,
        StFlush,
        StHold,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [pass_bw-1:0] np_q;
    logic [out_bw-1:0]  no_q;
    logic [pass_bw-1:0] pass_cnt_q;
    logic [out_bw-1:0]  out_cnt_q;
    logic               acc_q;

    logic               pop;
    logic               last_pass;
    logic               last_out;
    logic               accept;
    logic               launch;

    assign pop       = (state_q == StRead) && bus.ofifo_valid;
    assign last_pass = (pass_cnt_q == np_q - pass_bw'(1));
    assign last_out  = (out_cnt_q == no_q - out_bw'(1));
    assign accept    = (state_q == StHold) && bus.out_ready;
    assign launch    = (state_q == StIdle) && bus.start;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StClear;
            StClear: state_d = StRead;
            StRead:  if (pop && last_pass) state_d = StFlush;
            StFlush: state_d = StHold;
            StHold:  if (bus.out_ready) state_d = last_out ? StDone : StClear;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; acc comes from its own register
    always_comb begin
        bus.ofifo_rd  = pop;
        bus.clr       = (state_q == StClear);
        bus.out_valid = (state_q == StHold);
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone);
        bus.acc       = acc_q;
    end

    // Job sizes latched at launch (0 means 1) and pass/output counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            np_q       <= '0;
            no_q       <= '0;
            pass_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            if (launch) begin
                np_q       <= (bus.num_pass == '0) ? pass_bw'(1) : bus.num_pass;
                no_q       <= (bus.num_out == '0) ? out_bw'(1) : bus.num_out;
                pass_cnt_q <= '0;
                out_cnt_q  <= '0;
            end
            if (pop) begin
                pass_cnt_q <= last_pass ? '0 : pass_cnt_q + pass_bw'(1);
            end
            if (accept && !last_out) begin
                out_cnt_q <= out_cnt_q + out_bw'(1);
            end
        end
    end

    // Read data lands one cycle after the pop, so acc trails ofifo_rd by one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= pop;
        end
    end

`ifdef SFU_CTRL_PERF_EN
    logic [15:0] stall_q;
    logic        stalled;

    assign stalled = ((state_q == StRead) && !bus.ofifo_valid) ||
                     ((state_q == StHold) && !bus.out_ready);
    assign bus.stall_cycles = stall_q;

    // Saturating stall counter, restarted with each job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (launch) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
`endif

endmodule
